rep_pol_upd: RTL

REP_POL_UPD -- requirements
Module: rep_pol_upd

---
 rtl/rep_pol_pkg.sv | 16 +
 rtl/rep_pol_sat_inc.sv | 16 +
 rtl/rep_pol_upd.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rep_pol_pkg.sv
// Shared definitions for the usage-counter replacement policy updater.
// Holds the line count, way index type and the updater FSM state encoding.
package rep_pol_pkg;

    localparam int NUM_LINES = 4;
    localparam int ACC_CNT_W = 16;

    typedef logic [1:0] way_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        AGE    = 2'd2
    } state_t;

endpackage

// File: rtl/rep_pol_sat_inc.sv
// Saturating incrementer: adds one unless already at all-ones.
// sat_o flags that the result sits at the maximum representable value.
module rep_pol_sat_inc #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o,
    output logic         sat_o
);

    localparam logic [W-1:0] MAX_VAL = '1;

    assign val_o = (val_i == MAX_VAL) ? MAX_VAL : val_i + W'(1);
    assign sat_o = (val_o == MAX_VAL);

endmodule

// File: rtl/rep_pol_upd.sv
// Per-line usage counter updater feeding a least-used replacement decision.
// Each accepted access bumps or restarts one counter; periodic or saturation-driven aging halves all four.
module rep_pol_upd
    import rep_pol_pkg::*;
#(
    parameter int COUNT_W    = 32,
    parameter int AGE_PERIOD = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic [1:0]         acc_way,
    input  logic               acc_fill,
    output logic [COUNT_W-1:0] line_0,
    output logic [COUNT_W-1:0] line_1,
    output logic [COUNT_W-1:0] line_2,
    output logic [COUNT_W-1:0] line_3,
    output logic               upd_done,
    output logic               busy
);

    // One extra bit so AGE_PERIOD = 2^16 is still reachable by the 16-bit counter.
    localparam logic [ACC_CNT_W:0] PERIOD = (ACC_CNT_W + 1)'(AGE_PERIOD);

    state_t                              state_q, state_d;
    way_t                                way_q, way_d;
    logic                                fill_q, fill_d;
    logic [NUM_LINES-1:0][COUNT_W-1:0]   line_q, line_d;
    logic [ACC_CNT_W-1:0]                acc_cnt_q, acc_cnt_d;
    logic [1:0]                          age_idx_q, age_idx_d;
    logic                                upd_done_q, upd_done_d;

    logic [COUNT_W-1:0]                  inc_val;
    logic                                inc_sat;
    logic [ACC_CNT_W:0]                  cnt_next;

    rep_pol_sat_inc #(
        .W (COUNT_W)
    ) u_sat_inc (
        .val_i (line_q[way_q]),
        .val_o (inc_val),
        .sat_o (inc_sat)
    );

    assign cnt_next = {1'b0, acc_cnt_q} + (ACC_CNT_W + 1)'(1);

    always_comb begin
        state_d    = state_q;
        way_d      = way_q;
        fill_d     = fill_q;
        line_d     = line_q;
        acc_cnt_d  = acc_cnt_q;
        age_idx_d  = age_idx_q;
        upd_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc_valid) begin
                    way_d   = acc_way;
                    fill_d  = acc_fill;
                    state_d = UPDATE;
                end
            end

            UPDATE: begin
                line_d[way_q] = fill_q ? COUNT_W'(1) : inc_val;
                upd_done_d    = 1'b1;
                // A fill restarts the line at 1, so only a saturating hit may force aging.
                if ((cnt_next == PERIOD) || (!fill_q && inc_sat)) begin
                    state_d   = AGE;
                    acc_cnt_d = '0;
                    age_idx_d = 2'd0;
                end else begin
                    state_d   = IDLE;
                    acc_cnt_d = cnt_next[ACC_CNT_W-1:0];
                end
            end

            AGE: begin
                line_d[age_idx_q] = line_q[age_idx_q] >> 1;
                age_idx_d         = age_idx_q + 2'd1;
                if (age_idx_q == 2'd3) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            way_q      <= '0;
            fill_q     <= 1'b0;
            line_q     <= '0;
            acc_cnt_q  <= '0;
            age_idx_q  <= 2'd0;
            upd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            way_q      <= way_d;
            fill_q     <= fill_d;
            line_q     <= line_d;
            acc_cnt_q  <= acc_cnt_d;
            age_idx_q  <= age_idx_d;
            upd_done_q <= upd_done_d;
        end
    end

    // Ready is masked by reset so nothing is offered while the block is held.
    assign acc_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign upd_done  = upd_done_q;

    assign line_0 = line_q[0];
    assign line_1 = line_q[1];
    assign line_2 = line_q[2];
    assign line_3 = line_q[3];

endmodule
